// File: rtl/fft_pkg.sv
// Shared definitions for the FFT datapath stages: lane count, butterfly FSM
// state encoding and default-width lane-array types.
package fft_pkg;

  localparam int NUM_LANES = 16;
  localparam int SAMPLE_W  = 9;

  typedef enum logic [0:0] {
    FILL    = 1'b0,
    COMPUTE = 1'b1
  } bfly_state_t;

  // Lane arrays at the datapath's default sample width and at one bit of growth,
  // shared with neighbouring stages that pass whole blocks around.
  typedef logic signed [SAMPLE_W-1:0] sample_t;
  typedef logic signed [SAMPLE_W:0]   bfly_sample_t;
  typedef sample_t      sample_lanes_t [0:NUM_LANES-1];
  typedef bfly_sample_t bfly_lanes_t   [0:NUM_LANES-1];

endpackage

// File: rtl/fft_bfly_stage_if.sv
// Bus bundle of the butterfly stage: upstream block input, delay-line
// strobes/data/flags and the registered butterfly results.
interface fft_bfly_stage_if #(
  parameter int WIDTH        = 9,
  parameter int DELAY_LENGTH = 16
);
  import fft_pkg::*;

  localparam int IDX_W = $clog2(DELAY_LENGTH);

  logic                    in_valid;
  logic signed [WIDTH-1:0] in_real [0:NUM_LANES-1];
  logic signed [WIDTH-1:0] in_imag [0:NUM_LANES-1];

  logic                    sr_write;
  logic                    sr_read;
  logic signed [WIDTH-1:0] sr_real [0:NUM_LANES-1];
  logic signed [WIDTH-1:0] sr_imag [0:NUM_LANES-1];
  logic                    sr_full;
  logic                    sr_empty;

  logic                    out_valid;
  logic signed [WIDTH:0]   out_sum_real  [0:NUM_LANES-1];
  logic signed [WIDTH:0]   out_sum_imag  [0:NUM_LANES-1];
  logic signed [WIDTH:0]   out_diff_real [0:NUM_LANES-1];
  logic signed [WIDTH:0]   out_diff_imag [0:NUM_LANES-1];
  logic [IDX_W-1:0]        out_idx;
  logic                    frame_done;
  logic                    err;

  // The butterfly stage itself.
  modport slave (
    input  in_valid, in_real, in_imag, sr_real, sr_imag, sr_full, sr_empty,
    output sr_write, sr_read, out_valid, out_sum_real, out_sum_imag,
           out_diff_real, out_diff_imag, out_idx, frame_done, err
  );

  // Whoever feeds blocks in and hosts the delay line.
  modport master (
    output in_valid, in_real, in_imag, sr_real, sr_imag, sr_full, sr_empty,
    input  sr_write, sr_read, out_valid, out_sum_real, out_sum_imag,
           out_diff_real, out_diff_imag, out_idx, frame_done, err
  );

endinterface

// File: rtl/bfly_lane.sv
// One complex butterfly lane: sign-extends delayed and current samples by one
// bit and registers their sum and difference under a load enable. The extra
// bit makes both results exact for any pair of WIDTH-bit inputs.
module bfly_lane #(
  parameter int WIDTH = 9
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    ld,
  input  logic signed [WIDTH-1:0] dly_real,
  input  logic signed [WIDTH-1:0] dly_imag,
  input  logic signed [WIDTH-1:0] cur_real,
  input  logic signed [WIDTH-1:0] cur_imag,
  output logic signed [WIDTH:0]   sum_real,
  output logic signed [WIDTH:0]   sum_imag,
  output logic signed [WIDTH:0]   diff_real,
  output logic signed [WIDTH:0]   diff_imag
);

  logic signed [WIDTH:0] dr_s, di_s, cr_s, ci_s;
  logic signed [WIDTH:0] sum_real_r, sum_imag_r, diff_real_r, diff_imag_r;

  assign dr_s = {dly_real[WIDTH-1], dly_real};
  assign di_s = {dly_imag[WIDTH-1], dly_imag};
  assign cr_s = {cur_real[WIDTH-1], cur_real};
  assign ci_s = {cur_imag[WIDTH-1], cur_imag};

  // Result registers: load on an aligned pair, hold otherwise.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sum_real_r  <= '0;
      sum_imag_r  <= '0;
      diff_real_r <= '0;
      diff_imag_r <= '0;
    end else if (ld) begin
      sum_real_r  <= dr_s + cr_s;
      sum_imag_r  <= di_s + ci_s;
      diff_real_r <= dr_s - cr_s;
      diff_imag_r <= di_s - ci_s;
    end
  end

  assign sum_real  = sum_real_r;
  assign sum_imag  = sum_imag_r;
  assign diff_real = diff_real_r;
  assign diff_imag = diff_imag_r;

endmodule

// File: rtl/fft_bfly_stage.sv
// Radix-2 delay-feedback butterfly stage. The first half of every frame parks
// blocks in the external delay line; the second half reads them back in FIFO
// order and pairs each with the current block, delayed one cycle in cur_d so it
// lines up with the delay line's registered read data.
module fft_bfly_stage
  import fft_pkg::*;
#(
  parameter int WIDTH        = 9,
  parameter int DELAY_LENGTH = 16
) (
  input  logic                   clk,
  input  logic                   rstn,
  fft_bfly_stage_if.slave        bus
);

  localparam int               CNT_W    = $clog2(DELAY_LENGTH);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DELAY_LENGTH - 1);

  bfly_state_t             state_r;
  logic [CNT_W-1:0]        cnt_r;
  logic [CNT_W-1:0]        idx_d_r;
  logic [CNT_W-1:0]        out_idx_r;
  logic                    rd_d_r;
  logic                    chk_full_r;
  logic                    err_r;
  logic                    out_valid_r;
  logic                    frame_done_r;
  logic signed [WIDTH-1:0] cur_re_r [0:NUM_LANES-1];
  logic signed [WIDTH-1:0] cur_im_r [0:NUM_LANES-1];

  logic                    in_valid_s;
  logic                    last_s;
  logic                    sr_write_s;
  logic                    sr_read_s;
  logic signed [WIDTH:0]   sum_re_s  [0:NUM_LANES-1];
  logic signed [WIDTH:0]   sum_im_s  [0:NUM_LANES-1];
  logic signed [WIDTH:0]   diff_re_s [0:NUM_LANES-1];
  logic signed [WIDTH:0]   diff_im_s [0:NUM_LANES-1];

  // Gating with rstn keeps the delay-line strobes low while reset is held.
  assign in_valid_s = bus.in_valid & rstn;
  assign last_s     = (cnt_r == LAST_IDX);

  // Delay-line strobes: write while filling, read while computing.
  always_comb begin
    sr_write_s = 1'b0;
    sr_read_s  = 1'b0;
    case (state_r)
      FILL:    sr_write_s = in_valid_s;
      COMPUTE: sr_read_s  = in_valid_s;
      default: begin
        sr_write_s = 1'b0;
        sr_read_s  = 1'b0;
      end
    endcase
  end

  // Frame FSM, block counter and sticky protocol error.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r    <= FILL;
      cnt_r      <= '0;
      chk_full_r <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      chk_full_r <= 1'b0;
      // The delay line must report full right after the last parked block.
      if (chk_full_r && !bus.sr_full) begin
        err_r <= 1'b1;
      end
      case (state_r)
        FILL: begin
          if (in_valid_s) begin
            if (last_s) begin
              state_r    <= COMPUTE;
              cnt_r      <= '0;
              chk_full_r <= 1'b1;
            end else begin
              cnt_r <= cnt_r + CNT_W'(1);
            end
          end
        end
        COMPUTE: begin
          if (in_valid_s) begin
            if (bus.sr_empty) begin
              err_r <= 1'b1;
            end
            if (last_s) begin
              state_r <= FILL;
              cnt_r   <= '0;
            end else begin
              cnt_r <= cnt_r + CNT_W'(1);
            end
          end
        end
        default: begin
          state_r <= FILL;
          cnt_r   <= '0;
        end
      endcase
    end
  end

  // Alignment: hold the current block one cycle until the delayed block arrives.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_d_r  <= 1'b0;
      idx_d_r <= '0;
      for (int i = 0; i < NUM_LANES; i++) begin
        cur_re_r[i] <= '0;
        cur_im_r[i] <= '0;
      end
    end else if (in_valid_s && (state_r == COMPUTE)) begin
      rd_d_r  <= 1'b1;
      idx_d_r <= cnt_r;
      for (int i = 0; i < NUM_LANES; i++) begin
        cur_re_r[i] <= bus.in_real[i];
        cur_im_r[i] <= bus.in_imag[i];
      end
    end else begin
      rd_d_r <= 1'b0;
    end
  end

  // Result side-band registers, aligned with the lane result registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid_r  <= 1'b0;
      out_idx_r    <= '0;
      frame_done_r <= 1'b0;
    end else begin
      out_valid_r  <= rd_d_r;
      out_idx_r    <= idx_d_r;
      frame_done_r <= rd_d_r && (idx_d_r == LAST_IDX);
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    bfly_lane #(.WIDTH(WIDTH)) u_lane (
      .clk       (clk),
      .rstn      (rstn),
      .ld        (rd_d_r),
      .dly_real  (bus.sr_real[g]),
      .dly_imag  (bus.sr_imag[g]),
      .cur_real  (cur_re_r[g]),
      .cur_imag  (cur_im_r[g]),
      .sum_real  (sum_re_s[g]),
      .sum_imag  (sum_im_s[g]),
      .diff_real (diff_re_s[g]),
      .diff_imag (diff_im_s[g])
    );
  end

  assign bus.sr_write      = sr_write_s;
  assign bus.sr_read       = sr_read_s;
  assign bus.out_valid     = out_valid_r;
  assign bus.out_idx       = out_idx_r;
  assign bus.frame_done    = frame_done_r;
  assign bus.err           = err_r;
  assign bus.out_sum_real  = sum_re_s;
  assign bus.out_sum_imag  = sum_im_s;
  assign bus.out_diff_real = diff_re_s;
  assign bus.out_diff_imag = diff_im_s;

endmodule

// File: tb/tb_fft_bfly_stage.sv
// Bench for fft_bfly_stage: hosts a behavioural delay line, drives frames of
// blocks (fixed, extreme and random, with and without gaps) and compares every
// result against a frame-position/FIFO reference model.
`timescale 1ns/1ps
module tb_fft_bfly_stage;
  import fft_pkg::*;

  localparam int W   = 9;
  localparam int OW1 = W + 1;
  localparam int DL  = 16;
  localparam int NL  = NUM_LANES;
  localparam int PW  = NL * W;
  localparam int OW  = NL * OW1;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  fft_bfly_stage_if #(.WIDTH(W), .DELAY_LENGTH(DL)) bus ();

  fft_bfly_stage #(.WIDTH(W), .DELAY_LENGTH(DL)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [PW-1:0] pk_in(input logic signed [W-1:0] a [0:NL-1]);
    logic [PW-1:0] p;
    for (int l = 0; l < NL; l++) p[l*W +: W] = a[l];
    return p;
  endfunction

  function automatic logic [OW-1:0] pk_o(input logic signed [OW1-1:0] a [0:NL-1]);
    logic [OW-1:0] p;
    for (int l = 0; l < NL; l++) p[l*OW1 +: OW1] = a[l];
    return p;
  endfunction

  function automatic logic [PW-1:0] rand_blk();
    logic [PW-1:0] b;
    for (int l = 0; l < NL; l++) b[l*W +: W] = W'($urandom);
    return b;
  endfunction

  function automatic logic [PW-1:0] const_blk(input int v);
    logic [PW-1:0] b;
    for (int l = 0; l < NL; l++) b[l*W +: W] = W'(v);
    return b;
  endfunction

  // ---------------- behavioural delay line (FIFO of blocks) ----------------
  logic [PW-1:0] dl_re_q[$];
  logic [PW-1:0] dl_im_q[$];
  int            dl_cnt   = 0;
  bit            force_nf = 1'b0;

  assign bus.sr_full  = (dl_cnt == DL) && !force_nf;
  assign bus.sr_empty = (dl_cnt == 0);

  initial begin
    for (int l = 0; l < NL; l++) begin
      bus.sr_real[l] = '0;
      bus.sr_imag[l] = '0;
    end
    forever begin
      @(posedge clk or negedge rstn);
      if (!rstn) begin
        dl_re_q.delete();
        dl_im_q.delete();
        dl_cnt <= 0;
        for (int l = 0; l < NL; l++) begin
          bus.sr_real[l] <= '0;
          bus.sr_imag[l] <= '0;
        end
      end else begin
        if (bus.sr_read && dl_re_q.size() > 0) begin
          logic [PW-1:0] r, i;
          r = dl_re_q.pop_front();
          i = dl_im_q.pop_front();
          for (int l = 0; l < NL; l++) begin
            bus.sr_real[l] <= r[l*W +: W];
            bus.sr_imag[l] <= i[l*W +: W];
          end
        end
        if (bus.sr_write) begin
          dl_re_q.push_back(pk_in(bus.in_real));
          dl_im_q.push_back(pk_in(bus.in_imag));
        end
        dl_cnt <= dl_re_q.size();
      end
    end
  end

  // ---------------- reference model ----------------
  typedef struct {
    int            due;
    int            idx;
    logic [OW-1:0] sr, si, dr, di;
  } exp_t;

  exp_t          exp_q[$];
  logic [PW-1:0] fill_re_q[$];
  logic [PW-1:0] fill_im_q[$];
  int            pos = 0;
  int            cyc = 0;

  initial forever begin
    @(posedge clk);
    cyc <= cyc + 1;
  end

  task automatic model_reset();
    exp_q.delete();
    fill_re_q.delete();
    fill_im_q.delete();
    pos = 0;
  endtask

  // One cycle of upstream input; valid blocks update the model.
  task automatic drive(input bit v, input logic [PW-1:0] re, input logic [PW-1:0] im);
    @(posedge clk);
    #1;
    bus.in_valid = v;
    for (int l = 0; l < NL; l++) begin
      bus.in_real[l] = re[l*W +: W];
      bus.in_imag[l] = im[l*W +: W];
    end
    #1;
    if (v) begin
      check_eq("sr_write", bus.sr_write, pos < DL);
      check_eq("sr_read", bus.sr_read, pos >= DL);
      if (pos < DL) begin
        fill_re_q.push_back(re);
        fill_im_q.push_back(im);
      end else begin
        exp_t e;
        logic [PW-1:0] fr, fi;
        int dre, dim, cre, cim;
        fr = fill_re_q.pop_front();
        fi = fill_im_q.pop_front();
        e.due = cyc + 2;
        e.idx = pos - DL;
        for (int l = 0; l < NL; l++) begin
          dre = $signed(fr[l*W +: W]);
          dim = $signed(fi[l*W +: W]);
          cre = $signed(re[l*W +: W]);
          cim = $signed(im[l*W +: W]);
          e.sr[l*OW1 +: OW1] = OW1'(dre + cre);
          e.si[l*OW1 +: OW1] = OW1'(dim + cim);
          e.dr[l*OW1 +: OW1] = OW1'(dre - cre);
          e.di[l*OW1 +: OW1] = OW1'(dim - cim);
        end
        exp_q.push_back(e);
      end
      pos = (pos + 1) % (2 * DL);
    end else begin
      check_eq("gap_strobes", {bus.sr_write, bus.sr_read}, 2'b00);
    end
  endtask

  // ---------------- output monitor ----------------
  logic [OW-1:0] last_sr = '0, last_si = '0, last_dr = '0, last_di = '0;

  initial forever begin
    logic [OW-1:0] osr, osi, odr, odi;
    exp_t e;
    @(negedge clk);
    osr = pk_o(bus.out_sum_real);
    osi = pk_o(bus.out_sum_imag);
    odr = pk_o(bus.out_diff_real);
    odi = pk_o(bus.out_diff_imag);
    if (!rstn) begin
      last_sr = '0; last_si = '0; last_dr = '0; last_di = '0;
    end else if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      e = exp_q.pop_front();
      check_eq("out_valid", bus.out_valid, 1'b1);
      check_eq("sum_real", osr, e.sr);
      check_eq("sum_imag", osi, e.si);
      check_eq("diff_real", odr, e.dr);
      check_eq("diff_imag", odi, e.di);
      check_eq("out_idx", bus.out_idx, e.idx);
      check_eq("frame_done", bus.frame_done, e.idx == DL - 1);
      last_sr = osr; last_si = osi; last_dr = odr; last_di = odi;
    end else begin
      check_eq("idle_valid", bus.out_valid, 1'b0);
      check_eq("idle_done", bus.frame_done, 1'b0);
      check_eq("hold_sum", {osr, osi}, {last_sr, last_si});
      check_eq("hold_diff", {odr, odi}, {last_dr, last_di});
    end
  end

  // ---------------- stimulus ----------------
  // mode 0: ramp fill / unit compute, 1: extreme lanes 0..2, 2: random.
  task automatic run_frame(input int mode, input int gap_pct, input int nblk);
    for (int k = 0; k < nblk; k++) begin
      logic [PW-1:0] re, im;
      int j;
      j = k % DL;
      for (int g = 0; g < 3 && $urandom_range(0, 99) < gap_pct; g++)
        drive(1'b0, rand_blk(), rand_blk());
      re = rand_blk();
      im = rand_blk();
      if (mode == 0) begin
        re = (k < DL) ? const_blk(j)  : const_blk(1);
        im = (k < DL) ? const_blk(-j) : const_blk(1);
      end else if (mode == 1) begin
        re[0*W +: W] = (k < DL) ? -9'sd256 : 9'sd255;
        re[1*W +: W] = 9'sd255;
        re[2*W +: W] = -9'sd256;
      end
      drive(1'b1, re, im);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, rand_blk(), rand_blk());
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_valid"}, bus.out_valid, 1'b0);
    check_eq({tag, "_done"}, bus.frame_done, 1'b0);
    check_eq({tag, "_idx"}, bus.out_idx, 4'd0);
    check_eq({tag, "_err"}, bus.err, 1'b0);
    check_eq({tag, "_strobes"}, {bus.sr_write, bus.sr_read}, 2'b00);
    check_eq({tag, "_sum"}, {pk_o(bus.out_sum_real), pk_o(bus.out_sum_imag)}, '0);
    check_eq({tag, "_diff"}, {pk_o(bus.out_diff_real), pk_o(bus.out_diff_imag)}, '0);
  endtask

  initial begin
    bus.in_valid = 1'b1;
    for (int l = 0; l < NL; l++) begin
      bus.in_real[l] = W'($urandom);
      bus.in_imag[l] = W'($urandom);
    end

    // Reset held with in_valid high.
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    bus.in_valid = 1'b0;
    @(negedge clk);
    rstn = 1'b1;

    // Single frame: ramp against unit blocks.
    run_frame(0, 0, 2 * DL);
    idle(3);

    // Extremes; the last result stays on the outputs.
    run_frame(1, 0, 2 * DL);
    idle(3);
    check_eq("ext_sum0", {bus.out_sum_real[0]}, 10'h3FF);
    check_eq("ext_diff0", {bus.out_diff_real[0]}, 10'h201);
    check_eq("ext_sum1", {bus.out_sum_real[1]}, 10'h1FE);
    check_eq("ext_diff1", {bus.out_diff_real[1]}, 10'h000);
    check_eq("ext_sum2", {bus.out_sum_real[2]}, 10'h200);

    // Random gaps in both halves.
    run_frame(0, 40, 2 * DL);
    run_frame(2, 40, 2 * DL);
    idle(3);

    // Three back-to-back frames.
    for (int f = 0; f < 3; f++) run_frame(2, 0, 2 * DL);
    idle(3);
    check_eq("b2b_err", bus.err, 1'b0);

    // Reset after the fifth compute block.
    run_frame(2, 0, DL + 5);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    rstn = 1'b0;
    model_reset();
    #1;
    check_reset_outputs("midrst");
    bus.in_valid = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    run_frame(2, 20, 2 * DL);
    idle(3);
    check_eq("post_rst_err", bus.err, 1'b0);

    // Delay line not full at the FILL->COMPUTE boundary.
    force_nf = 1'b1;
    run_frame(2, 0, DL);
    idle(3);
    check_eq("err_set", bus.err, 1'b1);
    force_nf = 1'b0;
    idle(5);
    check_eq("err_sticky", bus.err, 1'b1);
    @(posedge clk);
    #1;
    rstn = 1'b0;
    model_reset();
    #1;
    check_eq("err_cleared", bus.err, 1'b0);
    @(negedge clk);
    rstn = 1'b1;
    run_frame(2, 0, 2 * DL);
    idle(4);
    check_eq("drain", exp_q.size(), 0);
    check_eq("final_err", bus.err, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
